// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the sequential divider.
// Contents:
//   ALU_W        - default datapath width
//   div_state_e  - divider control states
//   clog2()      - counter width helper (never returns less than 1)
package alu_pkg;

    localparam int unsigned ALU_W = 64;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StRun,
        StFix,
        StDone
    } div_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// Signals:
//   in_valid, dividend, divisor   - operand request (requester -> divider)
//   in_ready                      - divider idle and able to accept
//   out_valid, quotient,
//   remainder, div0, ovf          - result (divider -> consumer), held until accepted
//   out_ready                     - consumer accepts result
// Modports: master = requester/consumer side, slave = divider side.
interface seq_divider_if import alu_pkg::*; #(
    parameter int unsigned w = ALU_W
) ();

    logic         in_valid;
    logic         in_ready;
    logic [w-1:0] dividend;
    logic [w-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [w-1:0] quotient;
    logic [w-1:0] remainder;
    logic         div0;
    logic         ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div0, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div0, ovf
    );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// Ports:
//   rem, quo   - current partial remainder / quotient-dividend shift register
//   dvs        - divisor magnitude (up to 2^(w-1), so w unsigned bits suffice)
//   rem_next   - partial remainder after this iteration
//   quo_next   - shift register after this iteration, new quotient bit in LSB
module div_step import alu_pkg::*; #(
    parameter int unsigned w = ALU_W
) (
    input  logic [w-1:0] rem,
    input  logic [w-1:0] quo,
    input  logic [w-1:0] dvs,
    output logic [w-1:0] rem_next,
    output logic [w-1:0] quo_next
);

    logic [w:0] shifted;
    logic [w:0] trial;

    // rem < dvs <= 2^(w-1) always holds, so the shifted value fits in w+1 bits
    // and the sign of the w+1-bit trial is the restore decision.
    always_comb begin
        shifted  = {rem, quo[w-1]};
        trial    = shifted - {1'b0, dvs};
        quo_next = {quo[w-2:0], ~trial[w]};
        rem_next = trial[w] ? shifted[w-1:0] : trial[w-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: one quotient bit per clock, quotient truncated
// toward zero, remainder takes the sign of the dividend.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - seq_divider_if slave: operand handshake in, result handshake out
module seq_divider import alu_pkg::*; #(
    parameter int unsigned w = ALU_W
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);

    localparam int unsigned     CntW    = clog2(w);
    localparam logic [CntW-1:0] LastCnt = CntW'(w - 1);
    localparam logic [w-1:0]    MinVal  = {1'b1, {(w-1){1'b0}}};

    div_state_e state_q, state_d;

    logic [CntW-1:0] cnt_q;
    logic [w-1:0]    dividend_q, divisor_q;
    logic            neg_dividend_q, neg_divisor_q;
    logic [w-1:0]    rem_q, quo_q, dvs_q;
    logic [w-1:0]    quotient_q, remainder_q;
    logic            div0_q, ovf_q;
    logic [w-1:0]    rem_next, quo_next;
    logic            is_div0, is_ovf, is_special;

    div_step #(.w(w)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .dvs      (dvs_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_comb begin
        is_div0    = (divisor_q == '0);
        is_ovf     = (dividend_q == MinVal) && (divisor_q == '1);
        is_special = is_div0 || is_ovf;
        state_d    = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StPrep;
            // Special cases still pass through FIX so every result retires
            // from the same stage, giving them a fixed two-cycle latency.
            StPrep:  state_d = is_special ? StFix : StRun;
            StRun:   if (cnt_q == LastCnt) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            dividend_q     <= '0;
            divisor_q      <= '0;
            neg_dividend_q <= 1'b0;
            neg_divisor_q  <= 1'b0;
            rem_q          <= '0;
            quo_q          <= '0;
            dvs_q          <= '0;
            quotient_q     <= '0;
            remainder_q    <= '0;
            div0_q         <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        dividend_q     <= bus.dividend;
                        divisor_q      <= bus.divisor;
                        neg_dividend_q <= bus.dividend[w-1];
                        neg_divisor_q  <= bus.divisor[w-1];
                        div0_q         <= 1'b0;
                        ovf_q          <= 1'b0;
                    end
                end
                StPrep: begin
                    cnt_q <= '0;
                    if (is_div0) begin
                        quotient_q  <= '1;
                        remainder_q <= dividend_q;
                        div0_q      <= 1'b1;
                    end else if (is_ovf) begin
                        quotient_q  <= MinVal;
                        remainder_q <= '0;
                        ovf_q       <= 1'b1;
                    end else begin
                        // Negating -2^(w-1) yields 2^(w-1), correct as unsigned.
                        quo_q <= neg_dividend_q ? -dividend_q : dividend_q;
                        dvs_q <= neg_divisor_q ? -divisor_q : divisor_q;
                        rem_q <= '0;
                    end
                end
                StRun: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt_q <= cnt_q + CntW'(1);
                end
                StFix: begin
                    if (!is_special) begin
                        quotient_q  <= (neg_dividend_q ^ neg_divisor_q) ? -quo_q : quo_q;
                        remainder_q <= neg_dividend_q ? -rem_q : rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div0      = div0_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases at w=8 and a randomized
// sweep at w=64, each result compared against an arithmetic reference model.
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_divider_if #(.w(8))  if8 ();
    seq_divider_if #(.w(64)) if64 ();

    seq_divider #(.w(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    seq_divider #(.w(64)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if64)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    endtask

    // Reference: plain signed arithmetic plus the two exception rules.
    function automatic void ref_div(input int w, input longint a, input longint b,
                                    output longint q, output longint r,
                                    output bit d0, output bit ov);
        longint mn;
        mn = -(longint'(1) << (w - 1));
        d0 = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q  = -1;
            r  = a;
            d0 = 1'b1;
        end else if (a == mn && b == -1) begin
            q  = mn;
            r  = 0;
            ov = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [63:0] sx8(input logic [7:0] v);
        return {{56{v[7]}}, v};
    endfunction

    function automatic logic [63:0] rd_ready(input bit wide);
        return 64'(wide ? if64.in_ready : if8.in_ready);
    endfunction
    function automatic logic [63:0] rd_valid(input bit wide);
        return 64'(wide ? if64.out_valid : if8.out_valid);
    endfunction
    function automatic logic [63:0] rd_q(input bit wide);
        return wide ? if64.quotient : sx8(if8.quotient);
    endfunction
    function automatic logic [63:0] rd_r(input bit wide);
        return wide ? if64.remainder : sx8(if8.remainder);
    endfunction
    function automatic logic [63:0] rd_d0(input bit wide);
        return 64'(wide ? if64.div0 : if8.div0);
    endfunction
    function automatic logic [63:0] rd_ovf(input bit wide);
        return 64'(wide ? if64.ovf : if8.ovf);
    endfunction

    task automatic drive(input bit wide, input bit v, input longint a, input longint b);
        if (wide) begin
            if64.in_valid = v;
            if64.dividend = a;
            if64.divisor  = b;
        end else begin
            if8.in_valid = v;
            if8.dividend = a[7:0];
            if8.divisor  = b[7:0];
        end
    endtask

    task automatic set_ready(input bit wide, input bit v);
        if (wide) if64.out_ready = v;
        else if8.out_ready = v;
    endtask

    // Full transaction: accept, measure latency, check result, consume.
    task automatic do_op(input bit wide, input longint a, input longint b, input bit early);
        int     w;
        int     lat;
        longint eq, er;
        bit     ed, eo;
        string  ctx;
        w   = wide ? 64 : 8;
        ctx = $sformatf("w%0d %0d/%0d", w, a, b);
        ref_div(w, a, b, eq, er, ed, eo);
        lat = 0;
        while (rd_ready(wide) != 64'd1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (rd_ready(wide) != 64'd1) begin
            check({ctx, " ready timeout"}, rd_ready(wide), 64'd1);
            return;
        end
        drive(wide, 1'b1, a, b);
        set_ready(wide, early);
        @(negedge clk);
        drive(wide, 1'b0, a, b);
        check({ctx, " busy after accept"}, rd_ready(wide), 64'd0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rd_valid(wide) != 64'd1 && lat < 200);
        check({ctx, " out_valid"}, rd_valid(wide), 64'd1);
        check({ctx, " latency"}, 64'(lat), 64'((ed || eo) ? 2 : w + 2));
        set_ready(wide, 1'b1);
        check({ctx, " quotient"}, rd_q(wide), 64'(eq));
        check({ctx, " remainder"}, rd_r(wide), 64'(er));
        check({ctx, " div0"}, rd_d0(wide), 64'(ed));
        check({ctx, " ovf"}, rd_ovf(wide), 64'(eo));
        @(negedge clk);
        set_ready(wide, 1'b0);
        check({ctx, " released"}, rd_valid(wide), 64'd0);
        check({ctx, " idle again"}, rd_ready(wide), 64'd1);
    endtask

    initial begin
        longint a, b, eq, er;
        bit     ed, eo, bad;
        int     lat;
        logic [7:0] q0, r0;

        drive(1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 0, 0);
        set_ready(1'b0, 1'b0);
        set_ready(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset in_ready", rd_ready(i[0]), 64'd1);
            check("reset out_valid", rd_valid(i[0]), 64'd0);
            check("reset quotient", rd_q(i[0]), 64'd0);
            check("reset remainder", rd_r(i[0]), 64'd0);
            check("reset flags", rd_d0(i[0]) | rd_ovf(i[0]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed w=8 cases, including sign combinations and boundaries.
        do_op(1'b0, 100, 7, 1'b0);
        do_op(1'b0, -100, 7, 1'b0);
        do_op(1'b0, 100, -7, 1'b0);
        do_op(1'b0, -100, -7, 1'b1);   // out_ready high before out_valid
        do_op(1'b0, 7, 0, 1'b0);
        do_op(1'b0, -128, -1, 1'b0);
        do_op(1'b0, -128, 1, 1'b0);
        do_op(1'b0, 5, -128, 1'b0);
        do_op(1'b0, -128, 3, 1'b0);
        do_op(1'b0, 127, 127, 1'b0);

        // Backpressure with a second operand queued on in_valid.
        drive(1'b0, 1'b1, 100, 7);
        @(negedge clk);
        drive(1'b0, 1'b1, -100, 7);
        lat = 0;
        while (!if8.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("bp out_valid", 64'(if8.out_valid), 64'd1);
        q0  = if8.quotient;
        r0  = if8.remainder;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if8.quotient !== q0 || if8.remainder !== r0 || !if8.out_valid || if8.in_ready)
                bad = 1'b1;
        end
        check("bp hold stable", 64'(bad), 64'd0);
        ref_div(8, 100, 7, eq, er, ed, eo);
        check("bp quotient", sx8(if8.quotient), 64'(eq));
        check("bp remainder", sx8(if8.remainder), 64'(er));
        set_ready(1'b0, 1'b1);
        @(negedge clk);
        set_ready(1'b0, 1'b0);
        check("bp idle after release", 64'(if8.in_ready), 64'd1);
        @(negedge clk);
        check("bp queued accepted", 64'(if8.in_ready), 64'd0);
        drive(1'b0, 1'b0, 0, 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!if8.out_valid && lat < 50);
        check("bp second latency", 64'(lat), 64'd10);
        ref_div(8, -100, 7, eq, er, ed, eo);
        check("bp second quotient", sx8(if8.quotient), 64'(eq));
        check("bp second remainder", sx8(if8.remainder), 64'(er));
        set_ready(1'b0, 1'b1);
        @(negedge clk);
        set_ready(1'b0, 1'b0);

        // Reset during the third RUN cycle discards the operation.
        drive(1'b0, 1'b1, 100, 7);
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst in_ready", 64'(if8.in_ready), 64'd1);
        check("midrst out_valid", 64'(if8.out_valid), 64'd0);
        check("midrst quotient", sx8(if8.quotient), 64'd0);
        check("midrst remainder", sx8(if8.remainder), 64'd0);
        check("midrst flags", 64'(if8.div0 | if8.ovf), 64'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if8.out_valid) bad = 1'b1;
        end
        check("midrst no partial result", 64'(bad), 64'd0);
        do_op(1'b0, 9, 3, 1'b0);

        // w=64 randomized sweep with the overflow corner forced first.
        do_op(1'b1, longint'(64'h8000_0000_0000_0000), -1, 1'b0);
        do_op(1'b1, longint'(64'h8000_0000_0000_0000), 1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            a = longint'({$urandom(), $urandom()});
            b = longint'({$urandom(), $urandom()});
            case ($urandom_range(0, 9))
                0: b = 0;
                1: b = -1;
                2: a = longint'(64'h8000_0000_0000_0000);
                3: b = longint'(int'($urandom_range(0, 40)) - 20);
                4: a = longint'(int'($urandom_range(0, 2000)) - 1000);
                default: ;
            endcase
            do_op(1'b1, a, b, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
